// File: rtl/regfile_snap_if.sv
// Register-file port bundle: write/read pointers, operand select, flag and snapshot controls.
interface regfile_snap_if #(
   parameter int W = 8,
   parameter int N = 8
);
   localparam int AW = $clog2(N);

   logic          we;
   logic [AW-1:0] ptr_w;
   logic [W-1:0]  di;
   logic [AW-1:0] ptr_a;
   logic [AW-1:0] ptr_b;
   logic          const_flag;
   logic [W-1:0]  imm;
   logic          ovf_we;
   logic          ovf_in;
   logic          save;
   logic          restore;
   logic [W-1:0]  do_a;
   logic [W-1:0]  do_b;
   logic [W-1:0]  store_value;
   logic          ovf_out;

   modport master (
      output we, ptr_w, di, ptr_a, ptr_b, const_flag, imm, ovf_we, ovf_in, save, restore,
      input  do_a, do_b, store_value, ovf_out
   );

   modport slave (
      input  we, ptr_w, di, ptr_a, ptr_b, const_flag, imm, ovf_we, ovf_in, save, restore,
      output do_a, do_b, store_value, ovf_out
   );
endinterface

// File: rtl/regfile_snap.sv
// Register file with hard-zero r0, flag register r(N-1), write-first read bypass
// and a one-deep shadow bank supporting save, restore and swap.
module regfile_snap #(
   parameter int W = 8,
   parameter int N = 8
) (
   input logic           clk,
   input logic           reset,
   regfile_snap_if.slave bus
);
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] FLAG_IDX = AW'(N - 1);

   logic [W-1:0] regs   [N];
   logic [W-1:0] shadow [N];

   logic [W-1:0] flag_word;
   logic         byp_en;
   logic [W-1:0] byp_data;
   logic [W-1:0] rd_a;
   logic [W-1:0] rd_b;

   assign flag_word = {{(W-1){1'b0}}, bus.ovf_in};

   // Entry 0 of both banks is cleared by reset and never written afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            regs[i]   <= '0;
            shadow[i] <= '0;
         end
      end else begin
         if (bus.save) begin
            for (int i = 1; i < N; i++) shadow[i] <= regs[i];
         end
         if (bus.restore) begin
            for (int i = 1; i < N; i++) regs[i] <= shadow[i];
         end else begin
            if (bus.we && bus.ptr_w != '0) regs[bus.ptr_w] <= bus.di;
            // Flag load comes last so it wins over a same-cycle write to r(N-1).
            if (bus.ovf_we) regs[N-1] <= flag_word;
         end
      end
   end

   always_comb begin
      byp_en   = bus.we && (bus.ptr_w != '0) && !bus.restore && !reset;
      byp_data = bus.di;
      if (bus.ptr_w == FLAG_IDX && bus.ovf_we) byp_data = flag_word;

      rd_a = '0;
      if (bus.ptr_a != '0) rd_a = regs[bus.ptr_a];
      if (byp_en && bus.ptr_a == bus.ptr_w) rd_a = byp_data;

      rd_b = '0;
      if (bus.ptr_b != '0) rd_b = regs[bus.ptr_b];
      if (byp_en && bus.ptr_b == bus.ptr_w) rd_b = byp_data;
   end

   assign bus.do_a        = rd_a;
   assign bus.do_b        = bus.const_flag ? bus.imm : rd_b;
   assign bus.store_value = (bus.ptr_w == '0) ? '0 : regs[bus.ptr_w];
   assign bus.ovf_out     = regs[N-1][0];

endmodule

// File: tb/tb_regfile_snap.sv
// Directed bench for regfile_snap (W=8, N=8) with hand-computed expected values.
module tb_regfile_snap;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   regfile_snap_if #(.W(8), .N(8)) bus ();

   regfile_snap #(.W(8), .N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we = 0; bus.ptr_w = 0; bus.di = 0; bus.ptr_a = 0; bus.ptr_b = 0;
      bus.const_flag = 0; bus.imm = 0; bus.ovf_we = 0; bus.ovf_in = 0;
      bus.save = 0; bus.restore = 0;
   endtask

   task automatic wr(input logic [2:0] p, input logic [7:0] d);
      bus.we = 1; bus.ptr_w = p; bus.di = d;
      tick();
      bus.we = 0;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] p, input logic [7:0] exp);
      bus.ptr_a = p;
      #1;
      check(tag, bus.do_a, exp);
   endtask

   task automatic check_all_zero(input string tag);
      for (int p = 0; p < 8; p++) begin
         bus.ptr_a = 3'(p); bus.ptr_b = 3'(p); bus.ptr_w = 3'(p);
         #1;
         check({tag, "_do_a"}, bus.do_a, 0);
         check({tag, "_do_b"}, bus.do_b, 0);
         check({tag, "_store"}, bus.store_value, 0);
      end
      check({tag, "_ovf"}, bus.ovf_out, 0);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
      check_all_zero("reset");

      // write-first bypass versus pre-write store_value
      bus.we = 1; bus.ptr_w = 3; bus.di = 8'h5A; bus.ptr_a = 3; bus.ptr_b = 3;
      #1;
      check("byp_do_a", bus.do_a, 8'h5A);
      check("byp_do_b", bus.do_b, 8'h5A);
      check("store_pre", bus.store_value, 8'h00);
      tick();
      bus.we = 0;
      #1;
      check("store_post", bus.store_value, 8'h5A);
      check("r3_post", bus.do_a, 8'h5A);

      // r0 is hard zero, immediate select
      bus.we = 1; bus.ptr_w = 0; bus.di = 8'hFF; bus.ptr_a = 0;
      #1;
      check("r0_no_byp", bus.do_a, 8'h00);
      tick();
      bus.we = 0;
      rd_check("r0_after", 0, 8'h00);
      bus.const_flag = 1; bus.imm = 8'h80; bus.ptr_b = 0;
      #1;
      check("imm_r0", bus.do_b, 8'h80);
      bus.ptr_b = 3;
      #1;
      check("imm_r3", bus.do_b, 8'h80);
      bus.const_flag = 0;
      #1;
      check("rb_r3", bus.do_b, 8'h5A);

      // flag register: ovf_we beats we
      bus.we = 1; bus.ptr_w = 7; bus.di = 8'h44; bus.ovf_we = 1; bus.ovf_in = 1; bus.ptr_a = 7;
      #1;
      check("flag_byp", bus.do_a, 8'h01);
      tick();
      idle();
      rd_check("r7_flag", 7, 8'h01);
      check("ovf_out1", bus.ovf_out, 1);
      bus.ovf_we = 1; bus.ovf_in = 0;
      tick();
      bus.ovf_we = 0;
      #1;
      check("ovf_out0", bus.ovf_out, 0);
      wr(7, 8'h45);
      rd_check("r7_we", 7, 8'h45);
      check("ovf_out_we", bus.ovf_out, 1);

      // save / restore
      wr(2, 8'h11);
      bus.save = 1; tick(); bus.save = 0;
      wr(2, 8'h22);
      rd_check("r2_live", 2, 8'h22);
      bus.restore = 1; tick(); bus.restore = 0;
      rd_check("r2_restored", 2, 8'h11);
      bus.restore = 1; bus.we = 1; bus.ptr_w = 2; bus.di = 8'h77; bus.ptr_a = 2;
      #1;
      check("restore_no_byp", bus.do_a, 8'h11);
      tick();
      bus.restore = 0; bus.we = 0;
      rd_check("restore_wins", 2, 8'h11);
      wr(2, 8'h33);
      bus.save = 1; bus.restore = 1; tick(); bus.save = 0; bus.restore = 0;
      rd_check("swap_live", 2, 8'h11);
      bus.restore = 1; tick(); bus.restore = 0;
      rd_check("swap_shadow", 2, 8'h33);
      bus.save = 1; bus.we = 1; bus.ptr_w = 4; bus.di = 8'hAB;
      tick();
      bus.save = 0; bus.we = 0;
      rd_check("save_wr_live", 4, 8'hAB);
      bus.restore = 1; tick(); bus.restore = 0;
      rd_check("save_wr_shadow", 4, 8'h00);
      rd_check("save_wr_r2", 2, 8'h33);

      // reset mid-sequence drops the write
      wr(5, 8'h12);
      wr(3, 8'h66);
      bus.save = 1; tick(); bus.save = 0;
      reset = 1; bus.we = 1; bus.ptr_w = 5; bus.di = 8'h99; bus.ptr_a = 5;
      bus.const_flag = 1; bus.imm = 8'h3C;
      #1;
      check("rst_no_byp", bus.do_a, 8'h12);
      check("rst_imm", bus.do_b, 8'h3C);
      tick();
      idle();
      reset = 0;
      check_all_zero("midrst");
      wr(3, 8'h55);
      bus.restore = 1; tick(); bus.restore = 0;
      rd_check("shadow_cleared", 3, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
